// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the single-cycle MIPS datapath.
// Presents pc to fetch with a valid/ready handshake and traps on misaligned targets.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target;
  logic [31:0] target_sel;
  logic        update;
  logic        trap;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  // stall wins over fetch_ready; controls are only looked at on this edge
  assign update = (state_q == StFetch) && fetch_ready && !stall;

  // Target mux: jump_reg > jump > branch > sequential
  always_comb begin
    target = pc_plus4;
    if (jump_reg) begin
      target = reg_target;
    end else if (jump) begin
      target = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      target = pc_plus4 + branch_offset;
    end
  end

  // Alignment handling: trap, or silently clear the low bits
  always_comb begin
    target_sel = target;
    trap       = 1'b0;
    if (ALIGN_CHECK) begin
      trap = update && (target[1:0] != 2'b00);
    end else begin
      target_sel[1:0] = 2'b00;
    end
  end

  // PC next value: load only on an accepted, non-trapping fetch
  always_comb begin
    pc_d = pc_q;
    if (update && !trap) begin
      pc_d = target_sel;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; HALT is left only through reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (trap) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; misaligned is sticky because HALT is terminal
  always_comb begin
    pc_valid   = 1'b0;
    misaligned = 1'b0;
    unique case (state_q)
      StFetch: pc_valid = 1'b1;
      StHalt:  misaligned = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus a randomized
// run checked against a behavioural model of the fetch sequence.
module tb_pc_next_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        fetch_ready;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        misaligned;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: idle = first cycle after reset, halt = trapped
  logic [31:0] m_pc;
  bit          m_idle;
  bit          m_halt;

  pc_next_unit #(
    .RESET_PC    (RESET_PC),
    .ALIGN_CHECK (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .fetch_ready   (fetch_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_valid      (pc_valid),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_target(input logic [31:0] cur);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jump_reg)          return reg_target;
    else if (jump)         return {seq[31:28], jump_target, 2'b00};
    else if (branch_taken) return seq + branch_offset;
    else                   return seq;
  endfunction

  task automatic set_ctl(input bit fr, input bit st, input bit br, input logic [31:0] off,
                         input bit j, input logic [25:0] jt, input bit jr,
                         input logic [31:0] rt);
    fetch_ready   = fr;
    stall         = st;
    branch_taken  = br;
    branch_offset = off;
    jump          = j;
    jump_target   = jt;
    jump_reg      = jr;
    reg_target    = rt;
  endtask

  // One clock edge; model advances with the inputs present at that edge
  task automatic tick();
    logic [31:0] t;
    t = model_target(m_pc);
    @(posedge clk);
    #1;
    if (m_halt) begin
      // frozen until reset
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (fetch_ready && !stall) begin
      if (t[1:0] != 2'b00) m_halt = 1'b1;
      else                 m_pc = t;
    end
  endtask

  // Pulse reset inside the low phase, away from the rising edge
  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    m_pc   = RESET_PC;
    m_idle = 1'b1;
    m_halt = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    set_ctl(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    reset_n = 1'b0;
    #3;
    n_total++;
    if (pc !== RESET_PC) $display("FAIL reset_pc got %h want %h", pc, RESET_PC);
    else n_pass++;
    n_total++;
    if (pc_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", pc_valid);
    else n_pass++;
    n_total++;
    if (misaligned !== 1'b0) $display("FAIL reset_misaligned got %b want 0", misaligned);
    else n_pass++;
    @(posedge clk);
    #1;
    m_pc   = RESET_PC;
    m_idle = 1'b1;
    m_halt = 1'b0;
    reset_n = 1'b1;
    #2;
    n_total++;
    if (pc_valid !== 1'b0) $display("FAIL first_cycle_valid got %b want 0", pc_valid);
    else n_pass++;
    tick();
    n_total++;
    if (pc_valid !== 1'b1 || pc !== 32'h0)
      $display("FAIL fetch_start got valid=%b pc=%h want valid=1 pc=0", pc_valid, pc);
    else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_total++;
      if (pc !== 32'(4 * i)) $display("FAIL seq_%0d got %h want %h", i, pc, 32'(4 * i));
      else n_pass++;
    end
    n_total++;
    if (pc_plus4 !== 32'd16) $display("FAIL pc_plus4 got %h want 00000010", pc_plus4);
    else n_pass++;
  endtask

  task automatic test_branch();
    set_ctl(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h8);
    tick();
    set_ctl(1'b1, 1'b0, 1'b1, 32'd504, 1'b0, 26'd0, 1'b0, 32'd0);
    tick();
    n_total++;
    if (pc !== 32'h0000_0204) $display("FAIL branch_fwd got %h want 00000204", pc);
    else n_pass++;
    set_ctl(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h20);
    tick();
    set_ctl(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'd0, 1'b0, 32'd0);
    tick();
    n_total++;
    if (pc !== 32'h0000_0014) $display("FAIL branch_back got %h want 00000014", pc);
    else n_pass++;
  endtask

  task automatic test_jump();
    set_ctl(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h4000_0010);
    tick();
    set_ctl(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 26'h000_0040, 1'b0, 32'd0);
    tick();
    n_total++;
    if (pc !== 32'h4000_0100) $display("FAIL jump got %h want 40000100", pc);
    else n_pass++;
    set_ctl(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h4000_0010);
    tick();
    set_ctl(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 26'h000_0040, 1'b1, 32'h0000_0080);
    tick();
    n_total++;
    if (pc !== 32'h0000_0080) $display("FAIL jr_priority got %h want 00000080", pc);
    else n_pass++;
  endtask

  task automatic test_hold_wrap();
    logic [31:0] held;
    held = pc;
    // Controls asserted while stalled must be ignored
    set_ctl(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 26'h123, 1'b1, 32'h500);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (pc !== held || pc_valid !== 1'b1)
        $display("FAIL stall_hold_%0d got pc=%h valid=%b want pc=%h valid=1", i, pc, pc_valid,
                 held);
      else n_pass++;
    end
    set_ctl(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h900);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if (pc !== held) $display("FAIL noready_hold_%0d got %h want %h", i, pc, held);
      else n_pass++;
    end
    set_ctl(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC);
    tick();
    n_total++;
    if (pc_plus4 !== 32'h0) $display("FAIL plus4_wrap got %h want 00000000", pc_plus4);
    else n_pass++;
    set_ctl(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    tick();
    n_total++;
    if (pc !== 32'h0) $display("FAIL seq_wrap got %h want 00000000", pc);
    else n_pass++;
  endtask

  task automatic test_trap();
    set_ctl(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h100);
    tick();
    set_ctl(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_1002);
    tick();
    n_total++;
    if (misaligned !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h100)
      $display("FAIL trap got mis=%b valid=%b pc=%h want mis=1 valid=0 pc=00000100",
               misaligned, pc_valid, pc);
    else n_pass++;
    set_ctl(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 26'd0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (pc !== 32'h100 || misaligned !== 1'b1 || pc_valid !== 1'b0)
        $display("FAIL halt_frozen_%0d got pc=%h mis=%b valid=%b want pc=00000100 mis=1 valid=0",
                 i, pc, misaligned, pc_valid);
      else n_pass++;
    end
    // Reset in mid-cycle, no clock edge in between
    reset_n = 1'b0;
    #1;
    n_total++;
    if (misaligned !== 1'b0 || pc !== RESET_PC || pc_valid !== 1'b0)
      $display("FAIL halt_reset got mis=%b pc=%h valid=%b want mis=0 pc=%h valid=0",
               misaligned, pc, pc_valid, RESET_PC);
    else n_pass++;
    #1;
    m_pc   = RESET_PC;
    m_idle = 1'b1;
    m_halt = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] off;
    logic [31:0] rt;
    for (int i = 0; i < 400; i++) begin
      off = {{20{$urandom_range(0, 1) == 1}}, 12'($urandom)};
      off[1:0] = 2'b00;
      rt = $urandom;
      if ($urandom_range(0, 15) != 0) rt[1:0] = 2'b00;
      set_ctl($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              off, $urandom_range(0, 4) == 0, 26'($urandom), $urandom_range(0, 5) == 0, rt);
      tick();
      n_total++;
      if (pc !== m_pc) $display("FAIL rand_pc[%0d] got %h want %h", i, pc, m_pc);
      else n_pass++;
      n_total++;
      if (pc_plus4 !== m_pc + 32'd4)
        $display("FAIL rand_plus4[%0d] got %h want %h", i, pc_plus4, m_pc + 32'd4);
      else n_pass++;
      n_total++;
      if (pc_valid !== (!m_idle && !m_halt))
        $display("FAIL rand_valid[%0d] got %b want %b", i, pc_valid, !m_idle && !m_halt);
      else n_pass++;
      n_total++;
      if (misaligned !== m_halt)
        $display("FAIL rand_mis[%0d] got %b want %b", i, misaligned, m_halt);
      else n_pass++;
      // Occasionally reset, more often once trapped
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 63) == 0) pulse_reset();
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_hold_wrap();
    test_trap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register plus next-PC selection for the single-cycle MIPS datapath.
- Sits directly downstream of the immediate shifter and consumes its output (sign-extended immediate << 2) as the branch offset.
- Also forms jump and jump-register targets.
- Presents the current PC to instruction fetch with a valid/ready handshake and traps on misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ALIGN_CHECK, 1, when 1 a target with addr[1:0] != 0 traps; when 0 the low bits are forced to 00.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; suppresses the PC update even on handshake.
- fetch_ready  in  1  fetch stage accepts the current pc.
- branch_taken  in  1  take branch this instruction.
- branch_offset  in  32  shifted immediate from the shifter, two's complement.
- jump  in  1  J/JAL.
- jump_target  in  26  instr[25:0].
- jump_reg  in  1  JR/JALR.
- reg_target  in  32  rs value for JR.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational, for link and branch base.
- pc_valid  out  1  pc is presented to fetch.
- misaligned  out  1  sticky trap flag.

Behaviour:
Reset (reset_n low, asynchronous):
- pc = RESET_PC, pc_valid = 0, misaligned = 0, state = IDLE.
- Deassertion takes effect at the next clk edge.

States:
- IDLE: pc_valid = 0. Goes to FETCH unconditionally after one cycle.
- FETCH: pc_valid = 1. An update occurs on a clk edge when pc_valid & fetch_ready & !stall; otherwise pc holds.
- HALT: pc_valid = 0, misaligned = 1, pc frozen. Exits only by reset.

Next-PC selection (one update per accepted fetch, latency 1 clk). Priority: jump_reg > jump > branch_taken > sequential.
- sequential: pc + 4.
- branch: pc_plus4 + branch_offset.
- jump: {pc_plus4[31:28], jump_target, 2'b00}.
- jump_reg: reg_target.

Arithmetic rules:
- All adds are 32-bit modulo 2^32; wrap-around is silent (0xFFFF_FFFC + 4 = 0).
- A negative branch_offset must produce a backward branch.

Alignment:
- With ALIGN_CHECK = 1, a selected target with [1:0] != 0 moves the FSM to HALT on that edge and sets misaligned. pc keeps the old value.
- With ALIGN_CHECK = 0, target[1:0] is cleared and no trap occurs.

Boundary conditions:
- Control inputs are sampled only on the updating edge and ignored otherwise.
- stall and fetch_ready both high: no update, stall wins.
- Multiple control inputs asserted together are resolved by priority only; this is not an error.
- Reset asserted in any state, including HALT or mid-handshake, returns to IDLE immediately.
- pc_plus4 follows pc combinationally in every state.

Test Plan:
- Reset with RESET_PC = 0: pc = 0 and pc_valid = 0 during the first cycle after release, then pc_valid = 1. Three accepted fetches then give pc = 4, 8, 12.
- Branch at pc = 0x8 with branch_taken = 1 and branch_offset = 504 (shifter output for immediate 126): next pc = 0x0000_0204. A second case with offset = 0xFFFF_FFF0 from pc = 0x20 gives 0x0000_0014.
- Jump at pc = 0x4000_0010 with jump_target = 26'h000_0040: next pc = 0x4000_0100. With jump_reg = 1 also asserted and reg_target = 0x0000_0080, next pc = 0x80 (priority).
- Hold and wrap: stall = 1 with fetch_ready = 1 for 3 cycles keeps pc constant. fetch_ready = 0 alone also holds. pc = 0xFFFF_FFFC sequential gives 0x0000_0000.
- Trap: jump_reg with reg_target = 0x0000_1002 sets misaligned = 1 and pc_valid = 0, with pc unchanged across 5 further cycles. Asserting reset_n low mid-HALT clears misaligned and gives pc = RESET_PC without waiting for a clk edge.
